// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-port memory bus controller and arbiter.
// Shares one req/ack memory bus between instruction fetch and the MEM stage.
// Data accesses win arbitration. A wait counter aborts transactions to a dead slave.
// The controller drives the 6-bit pipeline stall vector: bit0 PC .. bit5 WB, 1 = stop.
module mem_bus_ctrl #(
    parameter int WAIT_MAX = 16,   // cycles bus_req may wait for bus_ack before abort (>= 1)
    parameter int CNT_W    = 5     // wait counter width, must hold WAIT_MAX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err,
    output logic [5:0]  stall
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } state_e;

    // A pending data access stops PC..MEM, so MEM/WB receives a bubble.
    // A pending fetch stops only PC and IF, so IF/ID receives a bubble.
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [3:0]       bus_sel_q, bus_sel_d;

    logic busy;
    logic timeout;
    logic done;

    assign busy    = (state_q != IDLE);
    // An ack in the last allowed cycle still counts as a normal completion.
    assign timeout = busy && !bus_ack && (cnt_q == CNT_W'(WAIT_MAX - 1));
    assign done    = busy && (bus_ack || timeout);

    // Arbitration, transaction sequencing and wait counting.
    always_comb begin
        // NOTE: give every variable a default before the case, so no path leaves one unassigned and infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    state_d     = MEM_BUSY;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    bus_sel_d   = mem_sel;
                end else if (if_req) begin
                    state_d     = IF_BUSY;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                    bus_sel_d   = 4'b1111;
                end
            end
            IF_BUSY, MEM_BUSY: begin
                // Address, data, strobes and direction stay frozen until the bus is released.
                if (done) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and bus register bank. A reset drops any transaction in flight, and that transaction is not replayed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the pre-edge value of its peers.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
        end
    end

    // Stall vector, ready pulses, read data and the abort pulse.
    always_comb begin
        stall     = STALL_NONE;
        if_ready  = 1'b0;
        if_rdata  = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        bus_err   = 1'b0;
        // NOTE: reset also gates these combinational outputs, so the pipeline is released at once rather than at the next edge.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (mem_req) begin
                        stall = STALL_MEM;
                    end else if (if_req) begin
                        stall = STALL_IF;
                    end
                end
                IF_BUSY: begin
                    if (done) begin
                        if_ready = 1'b1;
                        bus_err  = timeout;
                        if_rdata = bus_ack ? bus_rdata : '0;
                    end else begin
                        stall = STALL_IF;
                    end
                end
                MEM_BUSY: begin
                    if (done) begin
                        mem_ready = 1'b1;
                        bus_err   = timeout;
                        // Stores and aborts return zero.
                        mem_rdata = (bus_ack && !bus_we_q) ? bus_rdata : '0;
                    end else begin
                        stall = STALL_MEM;
                    end
                end
                default: stall = STALL_NONE;
            endcase
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_sel   = bus_sel_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed testbench for mem_bus_ctrl with hand-computed expectations.
// Inputs change 1 ns after a rising edge. Outputs are sampled 1 ns later, within the same cycle.
module tb_mem_bus_ctrl;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;
    logic [5:0]  stall;

    int vectors;
    int miscompares;

    mem_bus_ctrl #(.WAIT_MAX(16), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_sel   (mem_sel),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_sel   (bus_sel),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Reset state, with reset still asserted.
        #1;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL rst_bus_req: got %b expected 0", bus_req); end
        vectors++; if (stall !== 6'b000000) begin miscompares++; $display("FAIL rst_stall: got %b expected 000000", stall); end
        vectors++; if ({if_ready, mem_ready, bus_err} !== 3'b000) begin miscompares++; $display("FAIL rst_pulses: got %b expected 000", {if_ready, mem_ready, bus_err}); end
        vectors++; if ({bus_addr, bus_wdata, bus_sel, bus_we} !== 69'd0) begin miscompares++; $display("FAIL rst_bus_fields: got %h expected 0", {bus_addr, bus_wdata, bus_sel, bus_we}); end
        // Release reset, then start a load that is killed mid-transaction.
        cyc();
        reset = 1'b0;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40; mem_sel = 4'hF;
        cyc();
        vectors++; if (bus_req !== 1'b1) begin miscompares++; $display("FAIL rst_pre_bus_req: got %b expected 1", bus_req); end
        vectors++; if (stall !== 6'b011111) begin miscompares++; $display("FAIL rst_pre_stall: got %b expected 011111", stall); end
        #2 reset = 1'b1;
        #1;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL rst_async_bus_req: got %b expected 0", bus_req); end
        vectors++; if (stall !== 6'b000000) begin miscompares++; $display("FAIL rst_async_stall: got %b expected 000000", stall); end
        // After release, a late ack for the dead transaction must be ignored.
        cyc();
        reset = 1'b0; mem_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5;
        #1;
        vectors++; if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL rst_stale_ack_ready: got %b expected 0", mem_ready); end
        vectors++; if (mem_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_stale_ack_rdata: got %h expected 0", mem_rdata); end
        cyc();
        bus_ack = 1'b0;
        #1;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL rst_idle_after: got %b expected 0", bus_req); end
    endtask

    task automatic test_load();
        cyc();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; mem_wdata = 32'h0; mem_sel = 4'hF;
        #1;
        vectors++; if (stall !== 6'b011111) begin miscompares++; $display("FAIL load_stall_c0: got %b expected 011111", stall); end
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL load_bus_req_c0: got %b expected 0", bus_req); end
        cyc();
        vectors++; if ({bus_req, bus_we, bus_addr} !== {1'b1, 1'b0, 32'h100}) begin miscompares++; $display("FAIL load_bus_c1: got %h expected %h", {bus_req, bus_we, bus_addr}, {1'b1, 1'b0, 32'h100}); end
        vectors++; if (stall !== 6'b011111) begin miscompares++; $display("FAIL load_stall_c1: got %b expected 011111", stall); end
        vectors++; if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL load_ready_c1: got %b expected 0", mem_ready); end
        cyc();
        vectors++; if (stall !== 6'b011111) begin miscompares++; $display("FAIL load_stall_c2: got %b expected 011111", stall); end
        cyc();
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        #1;
        vectors++; if (mem_ready !== 1'b1) begin miscompares++; $display("FAIL load_ready_ack: got %b expected 1", mem_ready); end
        vectors++; if (mem_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_rdata_ack: got %h expected deadbeef", mem_rdata); end
        vectors++; if (stall !== 6'b000000) begin miscompares++; $display("FAIL load_stall_ack: got %b expected 000000", stall); end
        vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL load_err_ack: got %b expected 0", bus_err); end
        vectors++; if (if_ready !== 1'b0) begin miscompares++; $display("FAIL load_if_ready_ack: got %b expected 0", if_ready); end
        mem_req = 1'b0;
        cyc();
        bus_ack = 1'b0;
        #1;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL load_bus_req_after: got %b expected 0", bus_req); end
        vectors++; if ({mem_ready, mem_rdata} !== 33'd0) begin miscompares++; $display("FAIL load_ready_after: got %h expected 0", {mem_ready, mem_rdata}); end
    endtask

    task automatic test_store();
        cyc();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h20; mem_wdata = 32'h12345678; mem_sel = 4'b0011;
        cyc();
        // Scramble the requester inputs: the bus must keep the granted values.
        mem_addr = 32'hFFFFFFFF; mem_wdata = 32'h0; mem_sel = 4'b1100; mem_we = 1'b0;
        #1;
        vectors++; if ({bus_req, bus_we, bus_addr, bus_wdata, bus_sel} !== {1'b1, 1'b1, 32'h20, 32'h12345678, 4'b0011}) begin miscompares++; $display("FAIL store_bus_c1: got %h expected %h", {bus_req, bus_we, bus_addr, bus_wdata, bus_sel}, {1'b1, 1'b1, 32'h20, 32'h12345678, 4'b0011}); end
        cyc();
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        #1;
        vectors++; if ({bus_req, bus_we, bus_addr, bus_wdata, bus_sel} !== {1'b1, 1'b1, 32'h20, 32'h12345678, 4'b0011}) begin miscompares++; $display("FAIL store_bus_ack: got %h expected %h", {bus_req, bus_we, bus_addr, bus_wdata, bus_sel}, {1'b1, 1'b1, 32'h20, 32'h12345678, 4'b0011}); end
        vectors++; if (mem_ready !== 1'b1) begin miscompares++; $display("FAIL store_ready_ack: got %b expected 1", mem_ready); end
        vectors++; if (mem_rdata !== 32'h0) begin miscompares++; $display("FAIL store_rdata_ack: got %h expected 0", mem_rdata); end
        mem_req = 1'b0;
        cyc();
        bus_ack = 1'b0;
        #1;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL store_bus_req_after: got %b expected 0", bus_req); end
    endtask

    task automatic test_back_to_back();
        cyc();
        if_req = 1'b1; if_addr = 32'h4;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_wdata = 32'h0; mem_sel = 4'hF;
        #1;
        vectors++; if (stall !== 6'b011111) begin miscompares++; $display("FAIL b2b_stall_c0: got %b expected 011111", stall); end
        cyc();
        vectors++; if ({bus_req, bus_addr} !== {1'b1, 32'h200}) begin miscompares++; $display("FAIL b2b_data_first: got %h expected %h", {bus_req, bus_addr}, {1'b1, 32'h200}); end
        bus_ack = 1'b1; bus_rdata = 32'h11112222;
        #1;
        vectors++; if ({mem_ready, if_ready} !== 2'b10) begin miscompares++; $display("FAIL b2b_data_ready: got %b expected 10", {mem_ready, if_ready}); end
        vectors++; if (mem_rdata !== 32'h11112222) begin miscompares++; $display("FAIL b2b_data_rdata: got %h expected 11112222", mem_rdata); end
        mem_req = 1'b0;
        cyc();
        bus_ack = 1'b0;
        #1;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL b2b_gap_bus_req: got %b expected 0", bus_req); end
        vectors++; if (stall !== 6'b000011) begin miscompares++; $display("FAIL b2b_gap_stall: got %b expected 000011", stall); end
        cyc();
        vectors++; if ({bus_req, bus_we, bus_addr, bus_wdata, bus_sel} !== {1'b1, 1'b0, 32'h4, 32'h0, 4'b1111}) begin miscompares++; $display("FAIL b2b_fetch_bus: got %h expected %h", {bus_req, bus_we, bus_addr, bus_wdata, bus_sel}, {1'b1, 1'b0, 32'h4, 32'h0, 4'b1111}); end
        vectors++; if (stall !== 6'b000011) begin miscompares++; $display("FAIL b2b_fetch_stall: got %b expected 000011", stall); end
        cyc();
        bus_ack = 1'b1; bus_rdata = 32'h00000013;
        #1;
        vectors++; if ({if_ready, mem_ready} !== 2'b10) begin miscompares++; $display("FAIL b2b_fetch_ready: got %b expected 10", {if_ready, mem_ready}); end
        vectors++; if (if_rdata !== 32'h00000013) begin miscompares++; $display("FAIL b2b_fetch_rdata: got %h expected 00000013", if_rdata); end
        vectors++; if (stall !== 6'b000000) begin miscompares++; $display("FAIL b2b_fetch_stall_ack: got %b expected 000000", stall); end
        if_req = 1'b0;
        cyc();
        bus_ack = 1'b0;
        #1;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL b2b_bus_req_after: got %b expected 0", bus_req); end
    endtask

    task automatic test_timeout();
        cyc();
        if_req = 1'b1; if_addr = 32'h80; bus_rdata = 32'hBADBAD00;
        #1;
        vectors++; if (stall !== 6'b000011) begin miscompares++; $display("FAIL to_stall_c0: got %b expected 000011", stall); end
        // bus_req is high for 16 cycles. The abort happens in the last of them.
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (i < 15) begin
                vectors++; if ({bus_req, bus_err, if_ready, stall} !== {3'b100, 6'b000011}) begin miscompares++; $display("FAIL to_wait_%0d: got %b expected %b", i, {bus_req, bus_err, if_ready, stall}, {3'b100, 6'b000011}); end
            end else begin
                vectors++; if ({bus_req, bus_err, if_ready, stall} !== {3'b111, 6'b000000}) begin miscompares++; $display("FAIL to_abort: got %b expected %b", {bus_req, bus_err, if_ready, stall}, {3'b111, 6'b000000}); end
                vectors++; if (if_rdata !== 32'h0) begin miscompares++; $display("FAIL to_abort_rdata: got %h expected 0", if_rdata); end
            end
        end
        if_req = 1'b0;
        cyc();
        vectors++; if ({bus_req, bus_err, if_ready, stall} !== 9'd0) begin miscompares++; $display("FAIL to_idle_after: got %b expected 0", {bus_req, bus_err, if_ready, stall}); end
    endtask

    task automatic test_timeout_ack();
        // An ack in the last allowed cycle completes normally and raises no error.
        cyc();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300; mem_sel = 4'hF;
        repeat (16) cyc();
        bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
        #1;
        vectors++; if ({mem_ready, bus_err, stall} !== {2'b10, 6'b000000}) begin miscompares++; $display("FAIL toack_flags: got %b expected %b", {mem_ready, bus_err, stall}, {2'b10, 6'b000000}); end
        vectors++; if (mem_rdata !== 32'h0BADF00D) begin miscompares++; $display("FAIL toack_rdata: got %h expected 0badf00d", mem_rdata); end
        mem_req = 1'b0;
        cyc();
        bus_ack = 1'b0;
        #1;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL toack_bus_req_after: got %b expected 0", bus_req); end
    endtask

    task automatic test_idle_ack();
        cyc();
        bus_ack = 1'b1; bus_rdata = 32'h55555555;
        #1;
        vectors++; if ({if_ready, mem_ready, bus_err, stall} !== 9'd0) begin miscompares++; $display("FAIL idle_ack_flags: got %b expected 0", {if_ready, mem_ready, bus_err, stall}); end
        vectors++; if ({if_rdata, mem_rdata} !== 64'd0) begin miscompares++; $display("FAIL idle_ack_rdata: got %h expected 0", {if_rdata, mem_rdata}); end
        cyc();
        bus_ack = 1'b0;
        #1;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL idle_ack_bus_req: got %b expected 0", bus_req); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_sel   = '0;
        bus_rdata = '0;
        bus_ack   = 1'b0;
        test_reset();
        test_load();
        test_store();
        test_back_to_back();
        test_timeout();
        test_timeout_ack();
        test_idle_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
